// File: rtl/poly_nco.sv
// Time-multiplexed polyphonic NCO: one phase accumulator per voice, one shared
// wavetable ROM, and one valid-qualified amplitude per voice on every sample tick.
module poly_nco #(
  parameter int SAMPLE_RATE    = 192000,
  parameter int VOICES         = 8,
  parameter int PHASE_BITS     = 32,
  parameter int INDEX_BITS     = 10,
  parameter int AMP_BITS       = 16,
  parameter int FREQ_BITS      = 20,
  parameter int FREQ_FRAC_BITS = 4,
  parameter int C_FRAC_BITS    = 16,
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  wr_en,
  input  logic [VW-1:0]         wr_voice,
  input  logic [FREQ_BITS-1:0]  wr_freq,
  input  logic [1:0]            wr_mode,
  input  logic                  wr_sync,
  output logic [INDEX_BITS-1:0] table_addr,
  input  logic [AMP_BITS-1:0]   table_q,
  output logic                  sample_valid,
  output logic [VW-1:0]         out_voice,
  output logic [AMP_BITS-1:0]   out_sample,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun
);

  // Hz-to-increment scale, rounded to nearest at elaboration.
  localparam logic [63:0] C_INC =
    ((64'd1 << (PHASE_BITS + C_FRAC_BITS)) + 64'(SAMPLE_RATE / 2)) / 64'(SAMPLE_RATE);
  localparam int PW = FREQ_BITS + 64;
  localparam int SH = C_FRAC_BITS + FREQ_FRAC_BITS;

  localparam logic [AMP_BITS-1:0] C_MSB = {1'b1, {(AMP_BITS-1){1'b0}}};
  localparam logic [AMP_BITS-1:0] C_POS = ~C_MSB;
  localparam logic [AMP_BITS-1:0] C_NEG = C_MSB | {{(AMP_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  w_advance;
  logic                  w_tickBusy;
  logic                  w_lastVoice;
  logic [VW-1:0]         r_voice;

  logic [PHASE_BITS-1:0] r_phase [VOICES];
  logic [PHASE_BITS-1:0] r_inc   [VOICES];
  logic [1:0]            r_mode  [VOICES];

  logic [PW-1:0]         w_prod;
  logic [PHASE_BITS-1:0] w_incNew;
  logic [PHASE_BITS-1:0] w_phaseCur;
  logic [PHASE_BITS-1:0] w_incCur;

  logic                  r_valid;
  logic                  r_last;
  logic [VW-1:0]         r_outVoice;
  logic [AMP_BITS-1:0]   r_p2;
  logic [1:0]            r_mode2;
  logic [AMP_BITS-1:0]   r_hold;
  logic                  r_overrun;
  logic [AMP_BITS-1:0]   w_q;
  logic [AMP_BITS-1:0]   w_tri;
  logic [AMP_BITS-1:0]   w_formed;

  assign w_prod      = PW'(wr_freq) * PW'(C_INC);
  assign w_incNew    = PHASE_BITS'(w_prod >> SH);
  assign w_phaseCur  = r_phase[r_voice];
  assign w_incCur    = r_inc[r_voice];
  assign w_lastVoice = (r_voice == VW'(VOICES - 1));

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_advance   = 1'b0;
    w_tickBusy  = sample_tick && (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (sample_tick) w_nextState = S_RUN;
      S_RUN: begin
        w_advance = 1'b1;
        if (w_lastVoice) w_nextState = S_DRAIN;
      end
      S_DRAIN: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)                       r_voice <= '0;
    else if (r_state == S_IDLE)       r_voice <= '0;
    else if (w_advance && !w_lastVoice) r_voice <= r_voice + VW'(1);
  end

  // A sync write beats the accumulate of the same voice in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < VOICES; i++) begin
        r_phase[i] <= '0;
        r_inc[i]   <= '0;
        r_mode[i]  <= 2'd0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (wr_en && wr_voice == VW'(i)) begin
          r_inc[i]  <= w_incNew;
          r_mode[i] <= wr_mode;
        end
        if (wr_en && wr_sync && wr_voice == VW'(i))
          r_phase[i] <= '0;
        else if (w_advance && r_voice == VW'(i))
          r_phase[i] <= w_phaseCur + w_incCur;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_outVoice <= '0;
      r_p2       <= '0;
      r_mode2    <= 2'd0;
      r_hold     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid   <= w_advance;
      r_last    <= w_advance && w_lastVoice;
      r_overrun <= r_overrun | w_tickBusy;
      if (w_advance) begin
        r_outVoice <= r_voice;
        r_p2       <= w_phaseCur[PHASE_BITS-1 -: AMP_BITS];
        r_mode2    <= r_mode[r_voice];
      end
      if (r_valid) r_hold <= w_formed;
    end
  end

  assign w_q   = r_p2[AMP_BITS-1] ? ~r_p2 : r_p2;
  assign w_tri = (w_q << 1) ^ C_MSB;

  always_comb begin
    w_formed = table_q;
    case (r_mode2)
      2'd0: w_formed = table_q;
      2'd1: w_formed = r_p2 ^ C_MSB;
      2'd2: w_formed = r_p2[AMP_BITS-1] ? C_NEG : C_POS;
      2'd3: w_formed = w_tri;
      default: w_formed = table_q;
    endcase
  end

  // The ROM answers one cycle late, so the table sample is mixed in as it arrives
  // and held once the valid cycle has passed.
  assign table_addr   = (r_state == S_RUN) ? w_phaseCur[PHASE_BITS-1 -: INDEX_BITS] : '0;
  assign sample_valid = r_valid;
  assign out_voice    = r_outVoice;
  assign out_sample   = r_valid ? w_formed : r_hold;
  assign frame_done   = r_last;
  assign busy         = (r_state != S_IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_poly_nco.sv
// Scoreboard bench for poly_nco: stimulus queues hand-computed samples per frame,
// an independent monitor pops and compares them whenever sample_valid is seen.
module tb_poly_nco;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_voice = 3'd0;
  logic [19:0] wr_freq = 20'd0;
  logic [1:0]  wr_mode = 2'd0;
  logic        wr_sync = 1'b0;
  logic [9:0]  table_addr;
  logic [15:0] table_q = 16'd0;
  logic        sample_valid;
  logic [2:0]  out_voice;
  logic [15:0] out_sample;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  voice;
    logic [15:0] sample;
    logic        done;
    int          cyc;
  } expect_t;

  expect_t     sbQ[$];
  logic [15:0] expFrame [8];
  logic [9:0]  expAddr3;

  poly_nco dut (
    .clock(clock), .reset(reset), .sample_tick(sample_tick),
    .wr_en(wr_en), .wr_voice(wr_voice), .wr_freq(wr_freq),
    .wr_mode(wr_mode), .wr_sync(wr_sync),
    .table_addr(table_addr), .table_q(table_q),
    .sample_valid(sample_valid), .out_voice(out_voice), .out_sample(out_sample),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous ROM stand-in whose data is simply its address.
  always @(posedge clock) table_q <= {6'd0, table_addr};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clock);
      if (sample_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedValid", 32'(out_voice), 32'hFFFF_FFFF);
        end else begin
          e = sbQ.pop_front();
          checkOutput("outVoice", 32'(out_voice), 32'(e.voice));
          checkOutput("outSample", 32'(out_sample), 32'(e.sample));
          checkOutput("frameDone", 32'(frame_done), 32'(e.done));
          checkOutput("validCycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic clearFrame();
    for (int k = 0; k < 8; k++) expFrame[k] = 16'd0;
  endtask

  task automatic writeVoice(input logic [2:0] v, input logic [19:0] f,
                            input logic [1:0] m, input logic s);
    @(negedge clock);
    wr_en = 1'b1; wr_voice = v; wr_freq = f; wr_mode = m; wr_sync = s;
    @(negedge clock);
    wr_en = 1'b0; wr_sync = 1'b0;
  endtask

  // One frame: tick, queue expectations, track busy and the voice-3 read address,
  // optionally inject a second tick or a sync write at a chosen frame offset.
  task automatic applyStimulus(input int extraOff, input int syncOff,
                               input logic [2:0] syncVoice, input logic [19:0] syncFreq,
                               input logic [1:0] syncMode);
    int n;
    expect_t e;
    @(negedge clock);
    n = cyc;
    sample_tick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.voice = 3'(k); e.sample = expFrame[k]; e.done = (k == 7); e.cyc = n + 2 + k;
      sbQ.push_back(e);
    end
    for (int c = n; c <= n + 10; c++) begin
      if (c > n) @(negedge clock);
      if (c == n + 1) sample_tick = 1'b0;
      if (extraOff != 0 && c == n + extraOff) sample_tick = 1'b1;
      if (extraOff != 0 && c == n + extraOff + 1) sample_tick = 1'b0;
      if (syncOff != 0 && c == n + syncOff) begin
        wr_en = 1'b1; wr_sync = 1'b1; wr_voice = syncVoice;
        wr_freq = syncFreq; wr_mode = syncMode;
      end
      if (syncOff != 0 && c == n + syncOff + 1) begin
        wr_en = 1'b0; wr_sync = 1'b0;
      end
      checkOutput("busy", 32'(busy), 32'((c >= n + 1) && (c <= n + 9)));
      if (c == n + 4) checkOutput("tableAddrV3", 32'(table_addr), 32'(expAddr3));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [15:0] sawSeq [5];
    logic [15:0] sqSeq  [4];
    logic [15:0] triSeq [4];
    int          addrSeq [5];
    expect_t     e;
    int          n;

    sawSeq  = '{16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h8000};
    sqSeq   = '{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001};
    triSeq  = '{16'h8000, 16'h0000, 16'h7FFE, 16'hFFFE};
    addrSeq = '{0, 256, 512, 768, 0};

    // Reset with a write that must be ignored.
    repeat (2) @(negedge clock);
    wr_en = 1'b1; wr_voice = 3'd1; wr_freq = 20'd768000; wr_mode = 2'd1;
    @(negedge clock);
    wr_en = 1'b0;
    checkOutput("rstValid", 32'(sample_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);
    checkOutput("rstSample", 32'(out_sample), 32'd0);
    checkOutput("rstVoice", 32'(out_voice), 32'd0);
    checkOutput("rstAddr", 32'(table_addr), 32'd0);
    checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    clearFrame();
    expAddr3 = 10'd0;
    applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);

    // Voice 0 saw at a quarter of the sample rate.
    writeVoice(3'd0, 20'd768000, 2'd1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      expFrame[0] = sawSeq[f];
      applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    end

    writeVoice(3'd0, 20'd768000, 2'd2, 1'b1);
    for (int f = 0; f < 4; f++) begin
      expFrame[0] = sqSeq[f];
      applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    end

    writeVoice(3'd0, 20'd768000, 2'd3, 1'b1);
    for (int f = 0; f < 4; f++) begin
      expFrame[0] = triSeq[f];
      applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    end

    writeVoice(3'd0, 20'd0, 2'd0, 1'b1);
    expFrame[0] = 16'd0;

    // Voice 3 sine: table address walks in quarter steps and the sample is the ROM data.
    writeVoice(3'd3, 20'd768000, 2'd0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      expAddr3 = 10'(addrSeq[f]);
      expFrame[3] = 16'(addrSeq[f]);
      applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    end
    writeVoice(3'd3, 20'd0, 2'd0, 1'b1);
    expFrame[3] = 16'd0;
    expAddr3 = 10'd0;

    // Sync on voice 2 landing in its own processing cycle.
    writeVoice(3'd2, 20'd768000, 2'd1, 1'b0);
    expFrame[2] = 16'h8000;
    applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    expFrame[2] = 16'hC000;
    applyStimulus(0, 3, 3'd2, 20'd768000, 2'd1);
    expFrame[2] = 16'h8000;
    applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    expFrame[2] = 16'hC000;
    applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);

    // Overrun from a second tick mid-frame.
    checkOutput("overrunClear", 32'(overrun), 32'd0);
    expFrame[2] = 16'h0000;
    applyStimulus(4, 0, 3'd0, 20'd0, 2'd0);
    checkOutput("overrunSet", 32'(overrun), 32'd1);
    expFrame[2] = 16'h4000;
    applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);
    checkOutput("overrunSticky", 32'(overrun), 32'd1);

    // Reset mid-frame: only voices 0..2 make it out.
    @(negedge clock);
    n = cyc;
    sample_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.voice = 3'(k); e.sample = (k == 2) ? 16'h8000 : 16'h0000;
      e.done = 1'b0; e.cyc = n + 2 + k;
      sbQ.push_back(e);
    end
    @(negedge clock);
    sample_tick = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midRstValid", 32'(sample_valid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstOverrun", 32'(overrun), 32'd0);
    checkOutput("midRstSample", 32'(out_sample), 32'd0);
    checkOutput("midRstVoice", 32'(out_voice), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);

    // Increments and modes were cleared by the reset.
    clearFrame();
    applyStimulus(0, 0, 3'd0, 20'd0, 2'd0);

    repeat (4) @(negedge clock);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
